// File: rtl/dstack_spill_if.sv
// Command and spill-RAM signal bundle for dstack_spill.
// No latency of its own; the stack is the slave and the core plus spill RAM are the master.
// Ports: valid/ready command handshake with movement, rotate, rot_addr and next_top;
//        top/second/third/rot_val/total_depth views; mem_req/ack spill port; fault pulses.
interface dstack_spill_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10,
    parameter int RA_W   = 4
);
    // core side
    logic              valid;
    logic              ready;
    logic [1:0]        movement;
    logic              rotate;
    logic [RA_W-1:0]   rot_addr;
    logic [WIDTH-1:0]  next_top;
    logic [WIDTH-1:0]  top;
    logic [WIDTH-1:0]  second;
    logic [WIDTH-1:0]  third;
    logic [WIDTH-1:0]  rot_val;
    logic [ADDR_W:0]   total_depth;
    logic              overflow;
    logic              underflow;
    // spill RAM side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_ack;
    logic [WIDTH-1:0]  mem_rdata;

    modport slave (
        input  valid, movement, rotate, rot_addr, next_top, mem_ack, mem_rdata,
        output ready, top, second, third, rot_val, total_depth, overflow, underflow,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output valid, movement, rotate, rot_addr, next_top, mem_ack, mem_rdata,
        input  ready, top, second, third, rot_val, total_depth, overflow, underflow,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dstack_spill.sv
// Data stack: DEPTH-entry register window with word-at-a-time spill/fill to a backing RAM.
// Latency: stack views are combinational; a threshold crossing drops ready next cycle, mem_req the cycle after.
// Backpressure: ready is low while a spill/fill is needed or in flight; the RAM stalls via mem_ack.
// Ports: clk, reset (async, active-high), bus (dstack_spill_if.slave: command, views, spill port, faults).
module dstack_spill #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 10,
    parameter int SPILL_HIGH = 12,
    parameter int SPILL_LOW  = 4,
    parameter int RA_W       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    dstack_spill_if.slave bus
);
    localparam int IW = $clog2(DEPTH);          // window index width
    localparam int CW = IW + 1;                 // window_count holds 0..DEPTH
    localparam int PW = ADDR_W + 1;             // spill_ptr holds 0..2^ADDR_W
    localparam int TW = ((CW > PW) ? CW : PW) + 1;

    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  win     [DEPTH];
    logic [WIDTH-1:0]  win_nxt [DEPTH];
    logic [CW-1:0]     count;
    logic [PW-1:0]     spill_ptr;
    logic [TW-1:0]     total_full;
    logic              need_spill, need_fill;
    logic              ready, accept, xfer_done, start_spill, start_fill;
    logic              push_full, pop_short;
    logic              mem_req_q, mem_we_q, overflow_q, underflow_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WIDTH-1:0]  mem_wdata_q;
    logic [IW-1:0]     spill_idx;
    logic [ADDR_W-1:0] fill_addr;

    assign total_full = TW'(count) + TW'(spill_ptr);
    // spill_ptr MSB set means every spill slot is occupied
    assign need_spill = (count > CW'(SPILL_HIGH)) && !spill_ptr[ADDR_W];
    assign need_fill  = (count < CW'(SPILL_LOW)) && (spill_ptr != '0);
    assign push_full  = (bus.movement == 2'b01) && (count == CW'(DEPTH));
    assign pop_short  = ((bus.movement == 2'b10) && (total_full == '0)) ||
                        ((bus.movement == 2'b11) && (total_full <= TW'(1)));
    assign spill_idx  = IW'(count - CW'(1));
    assign fill_addr  = ADDR_W'(spill_ptr - PW'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (need_spill && !accept) state_nxt = SPILL;
                else if (need_fill)        state_nxt = FILL;
            end
            SPILL:   if (xfer_done) state_nxt = IDLE;
            FILL:    if (xfer_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        ready       = (state == IDLE) && !need_spill && !need_fill;
        accept      = bus.valid && ready;
        // ack only counts while our request is actually up
        xfer_done   = mem_req_q && bus.mem_ack;
        start_spill = (state == IDLE) && (state_nxt == SPILL);
        start_fill  = (state == IDLE) && (state_nxt == FILL);
    end

    // ---------------- window next-value ----------------
    always_comb begin
        win_nxt = win;
        if (accept) begin
            case (bus.movement)
                2'b01:   for (int i = 1; i < DEPTH; i++)     win_nxt[i] = win[i-1];
                2'b10:   for (int i = 1; i < DEPTH - 1; i++) win_nxt[i] = win[i+1];
                2'b11:   for (int i = 1; i < DEPTH - 2; i++) win_nxt[i] = win[i+2];
                default: begin
                    if (bus.rotate) begin
                        for (int i = 1; i < DEPTH; i++)
                            if (RA_W'(i) <= bus.rot_addr) win_nxt[i] = win[i-1];
                    end
                end
            endcase
            // the core always supplies the new top, whatever the movement
            win_nxt[0] = bus.next_top;
        end else if ((state == FILL) && xfer_done) begin
            // fills only happen below SPILL_LOW, so count is a valid index here
            win_nxt[count[IW-1:0]] = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) win[i] <= win_nxt[i];
        end
    end

    // ---------------- occupancy and fault pulses ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            spill_ptr   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= accept && push_full;
            underflow_q <= accept && pop_short;
            if (accept) begin
                if (pop_short) begin
                    count     <= '0;
                    spill_ptr <= '0;
                end else begin
                    case (bus.movement)
                        2'b01:   if (!push_full) count <= count + CW'(1);
                        2'b10:   count <= count - CW'(1);
                        2'b11:   count <= count - CW'(2);
                        default: ;
                    endcase
                end
            end else if (xfer_done && (state == SPILL)) begin
                count     <= count - CW'(1);
                spill_ptr <= spill_ptr + PW'(1);
            end else if (xfer_done && (state == FILL)) begin
                count     <= count + CW'(1);
                spill_ptr <= spill_ptr - PW'(1);
            end
        end
    end

    // ---------------- spill port registers ----------------
    // address/data/we are captured at issue and held for the whole request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (start_spill) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= spill_ptr[ADDR_W-1:0];
            mem_wdata_q <= win[spill_idx];
        end else if (start_fill) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= fill_addr;
        end else if (xfer_done) begin
            mem_req_q   <= 1'b0;
        end
    end

    assign bus.ready       = ready;
    assign bus.top         = win[0];
    assign bus.second      = win[1];
    assign bus.third       = win[2];
    assign bus.rot_val     = win[bus.rot_addr];
    assign bus.total_depth = total_full[PW-1:0];
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_dstack_spill.sv
// Directed bench for dstack_spill: default instance (ADDR_W=10) and a tiny-spill instance (ADDR_W=1).
// Each instance has a spill RAM responder that acks a request in its second cycle.
module tb_dstack_spill;
    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    dstack_spill_if #(.WIDTH(32), .ADDR_W(10), .RA_W(4)) ifa ();
    dstack_spill_if #(.WIDTH(32), .ADDR_W(1),  .RA_W(4)) ifb ();

    dstack_spill u_dut   (.clk(clk), .reset(reset), .bus(ifa));
    dstack_spill #(.ADDR_W(1)) u_small (.clk(clk), .reset(reset), .bus(ifb));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // ---------------- spill RAM responders ----------------
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [2];
    int          a_lat = 2;
    int          a_age, b_age;
    int          a_spill_addr[$], a_fill_addr[$], b_spill_addr[$];
    logic [31:0] a_spill_data[$], b_spill_data[$];
    int          a_faults = 0;

    initial begin
        ifa.mem_ack = 0; ifa.mem_rdata = '0; a_age = 0;
        forever begin
            @(negedge clk);
            if (ifa.mem_ack) begin
                ifa.mem_ack = 0; a_age = 0;
            end else if (ifa.mem_req) begin
                a_age++;
                if (a_age >= a_lat) begin
                    ifa.mem_ack = 1;
                    if (ifa.mem_we) begin
                        mem_a[ifa.mem_addr] = ifa.mem_wdata;
                        a_spill_addr.push_back(int'(ifa.mem_addr));
                        a_spill_data.push_back(ifa.mem_wdata);
                    end else begin
                        ifa.mem_rdata = mem_a[ifa.mem_addr];
                        a_fill_addr.push_back(int'(ifa.mem_addr));
                    end
                end
            end else a_age = 0;
        end
    end

    initial begin
        ifb.mem_ack = 0; ifb.mem_rdata = '0; b_age = 0;
        forever begin
            @(negedge clk);
            if (ifb.mem_ack) begin
                ifb.mem_ack = 0; b_age = 0;
            end else if (ifb.mem_req) begin
                b_age++;
                if (b_age >= 2) begin
                    ifb.mem_ack = 1;
                    if (ifb.mem_we) begin
                        mem_b[ifb.mem_addr] = ifb.mem_wdata;
                        b_spill_addr.push_back(int'(ifb.mem_addr));
                        b_spill_data.push_back(ifb.mem_wdata);
                    end else ifb.mem_rdata = mem_b[ifb.mem_addr];
                end
            end else b_age = 0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ifa.overflow || ifa.underflow) a_faults++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one command at a negedge, hold until accepted, return at the following negedge.
    task automatic cmd(input bit b, input logic [1:0] mv, input logic rot,
                       input logic [3:0] ra, input logic [31:0] nt);
        int waited;
        waited = 0;
        if (b) begin
            ifb.valid = 1; ifb.movement = mv; ifb.rotate = rot; ifb.rot_addr = ra; ifb.next_top = nt;
        end else begin
            ifa.valid = 1; ifa.movement = mv; ifa.rotate = rot; ifa.rot_addr = ra; ifa.next_top = nt;
        end
        while (!(b ? ifb.ready : ifa.ready) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (b) check("b_cmd_accept", waited < 200, 1'b1);
        else   check("a_cmd_accept", waited < 200, 1'b1);
        if (waited < 200) @(posedge clk);
        @(negedge clk);
        ifa.valid = 0;
        ifb.valid = 0;
    endtask

    task automatic wait_ready_a();
        int w;
        w = 0;
        while (!ifa.ready && w < 100) begin @(negedge clk); w++; end
        check("a_idle_wait", w < 100, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        reset = 0;
        ifa.valid = 0; ifa.movement = 0; ifa.rotate = 0; ifa.rot_addr = 0; ifa.next_top = 0;
        ifb.valid = 0; ifb.movement = 0; ifb.rotate = 0; ifb.rot_addr = 0; ifb.next_top = 0;
        #1 reset = 1;
        #1;
        check("rst_ready",     ifa.ready, 1);
        check("rst_top",       ifa.top, 0);
        check("rst_second",    ifa.second, 0);
        check("rst_third",     ifa.third, 0);
        check("rst_rot_val",   ifa.rot_val, 0);
        check("rst_mem_req",   ifa.mem_req, 0);
        check("rst_mem_we",    ifa.mem_we, 0);
        check("rst_mem_addr",  ifa.mem_addr, 0);
        check("rst_mem_wdata", ifa.mem_wdata, 0);
        check("rst_total",     ifa.total_depth, 0);
        check("rst_overflow",  ifa.overflow, 0);
        check("rst_underflow", ifa.underflow, 0);
        check("rst_b_ready",   ifb.ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        check("post_rst_ready", ifa.ready, 1);

        // 13 pushes: the 13th crosses SPILL_HIGH
        for (int i = 1; i <= 12; i++) cmd(0, 2'b01, 0, 0, 32'(i));
        cmd(0, 2'b01, 0, 0, 32'd13);
        check("n1_ready",   ifa.ready, 0);
        check("n1_mem_req", ifa.mem_req, 0);
        @(negedge clk);
        check("n2_ready",     ifa.ready, 0);
        check("n2_mem_req",   ifa.mem_req, 1);
        check("n2_mem_we",    ifa.mem_we, 1);
        check("n2_mem_addr",  ifa.mem_addr, 0);
        check("n2_mem_wdata", ifa.mem_wdata, 1);
        @(negedge clk);
        check("n3_ready", ifa.ready, 0);
        @(negedge clk);
        check("n4_ready",   ifa.ready, 1);
        check("n4_mem_req", ifa.mem_req, 0);
        check("n4_total",   ifa.total_depth, 13);
        check("n4_top",     ifa.top, 13);
        check("spill0_cnt", a_spill_addr.size(), 1);

        // up to 20 pushes: spills 0..7 hold words 1..8
        for (int i = 14; i <= 20; i++) cmd(0, 2'b01, 0, 0, 32'(i));
        wait_ready_a();
        check("p20_total",     ifa.total_depth, 20);
        check("p20_spill_cnt", a_spill_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("spill_addr", (i < a_spill_addr.size()) ? a_spill_addr[i] : -1, i);
            check("spill_data", (i < a_spill_data.size()) ? a_spill_data[i] : 32'hffff_ffff, i + 1);
        end

        // 20 pops; next_top = second makes each pop expose the next word
        for (int k = 20; k >= 1; k--) begin
            check("pop_top", ifa.top, k);
            cmd(0, 2'b10, 0, 0, ifa.second);
        end
        wait_ready_a();
        check("pops_total",    ifa.total_depth, 0);
        check("fill_cnt",      a_fill_addr.size(), 8);
        for (int i = 0; i < 8; i++)
            check("fill_addr", (i < a_fill_addr.size()) ? a_fill_addr[i] : -1, 7 - i);
        check("pops_no_fault", a_faults, 0);

        // underflow: pop on empty, then pop twice with one entry
        cmd(0, 2'b10, 0, 0, 32'h0);
        check("uf1_pulse", ifa.underflow, 1);
        check("uf1_total", ifa.total_depth, 0);
        @(negedge clk);
        check("uf1_clear", ifa.underflow, 0);
        cmd(0, 2'b01, 0, 0, 32'h55);
        check("uf2_pre_total", ifa.total_depth, 1);
        cmd(0, 2'b11, 0, 0, 32'h77);
        check("uf2_pulse", ifa.underflow, 1);
        check("uf2_total", ifa.total_depth, 0);
        check("uf2_top",   ifa.top, 32'h77);
        @(negedge clk);
        check("uf2_clear", ifa.underflow, 0);
        check("uf_faults", a_faults, 2);

        // rotate: A,B,C,D with D on top, rot_addr 3
        cmd(0, 2'b01, 0, 0, 32'hA);
        cmd(0, 2'b01, 0, 0, 32'hB);
        cmd(0, 2'b01, 0, 0, 32'hC);
        cmd(0, 2'b01, 0, 0, 32'hD);
        ifa.rot_addr = 4'd3;
        #1;
        check("rot_pre_val", ifa.rot_val, 32'hA);
        check("rot_pre_top", ifa.top, 32'hD);
        cmd(0, 2'b00, 1, 4'd3, ifa.rot_val);
        check("rot_top",    ifa.top, 32'hA);
        check("rot_second", ifa.second, 32'hD);
        check("rot_third",  ifa.third, 32'hC);
        check("rot_val3",   ifa.rot_val, 32'hB);
        check("rot_total",  ifa.total_depth, 4);

        // small spill memory: 2 slots, window saturates at 16
        for (int i = 1; i <= 18; i++) cmd(1, 2'b01, 0, 0, 32'(i));
        check("b18_overflow", ifb.overflow, 0);
        check("b18_ready",    ifb.ready, 1);
        // total_depth is ADDR_W+1 = 2 bits on this instance, so 18 reads as 18 mod 4
        check("b18_total",    ifb.total_depth, 18 % 4);
        check("b_spill_cnt",  b_spill_addr.size(), 2);
        check("b_spill0",     (b_spill_data.size() > 0) ? b_spill_data[0] : 32'hffff_ffff, 1);
        check("b_spill1",     (b_spill_data.size() > 1) ? b_spill_data[1] : 32'hffff_ffff, 2);
        cmd(1, 2'b01, 0, 0, 32'd19);
        check("b19_overflow", ifb.overflow, 1);
        @(negedge clk);
        check("b19_clear",    ifb.overflow, 0);
        for (int i = 20; i <= 22; i++) cmd(1, 2'b01, 0, 0, 32'(i));
        check("b22_top",     ifb.top, 22);
        check("b22_second",  ifb.second, 21);
        check("b22_total",   ifb.total_depth, 18 % 4);
        check("b22_mem_req", ifb.mem_req, 0);

        // reset while a spill request is outstanding (RAM never acks)
        a_lat = 1000;
        for (int i = 1; i <= 9; i++) cmd(0, 2'b01, 0, 0, 32'h100 + 32'(i));
        w = 0;
        while (!ifa.mem_req && w < 20) begin @(negedge clk); w++; end
        check("mr_req_up", ifa.mem_req, 1);
        check("mr_wdata",  ifa.mem_wdata, 32'hB);
        check("mr_addr",   ifa.mem_addr, 0);
        #2 reset = 1;
        #1;
        check("mr_rst_req",   ifa.mem_req, 0);
        check("mr_rst_we",    ifa.mem_we, 0);
        check("mr_rst_wdata", ifa.mem_wdata, 0);
        check("mr_rst_ready", ifa.ready, 1);
        check("mr_rst_top",   ifa.top, 0);
        check("mr_rst_total", ifa.total_depth, 0);
        @(negedge clk);
        reset = 0;
        a_lat = 2;
        check("mr_rel_ready", ifa.ready, 1);
        @(negedge clk);
        check("mr_rel_ready2", ifa.ready, 1);
        check("mr_rel_req",    ifa.mem_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
